write_through_buffer: RTL and testbench

//  FIFO between the cache front-end write path and the write-through AXI write channel.

---
 rtl/write_through_buffer_if.sv | 37 +++
 rtl/write_through_buffer.sv | 115 +++++++++++
 tb/tb_write_through_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/write_through_buffer_if.sv
// Bundle of front-end push signals and the write-through channel head/handshake.
// The buffer takes the slave modport; the front-end/channel side takes master.
interface write_through_buffer_if #(
    parameter int unsigned FE_ADDR_W = 32,
    parameter int unsigned FE_DATA_W = 32,
    parameter int unsigned DEPTH_W   = 2
);
    localparam int unsigned FE_NBYTES = FE_DATA_W / 8;
    localparam int unsigned FE_BYTE_W = $clog2(FE_NBYTES);
    localparam int unsigned ADDR_W    = FE_ADDR_W - FE_BYTE_W;

    logic                  wtb_push;
    logic [ADDR_W-1:0]     wtb_addr;
    logic [FE_DATA_W-1:0]  wtb_wdata;
    logic [FE_NBYTES-1:0]  wtb_wstrb;
    logic                  wtb_full;
    logic                  wtb_empty;
    logic [DEPTH_W:0]      wtb_level;
    logic                  wtb_ovf;
    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [FE_DATA_W-1:0]  mem_wdata;
    logic [FE_NBYTES-1:0]  mem_wstrb;
    logic                  mem_ready;

    modport slave (
        input  wtb_push, wtb_addr, wtb_wdata, wtb_wstrb, mem_ready,
        output wtb_full, wtb_empty, wtb_level, wtb_ovf,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output wtb_push, wtb_addr, wtb_wdata, wtb_wstrb, mem_ready,
        input  wtb_full, wtb_empty, wtb_level, wtb_ovf,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/write_through_buffer.sv
// Posted-write FIFO between the cache write path and the write-through channel.
// The head entry stays in storage until the channel reports completion, so it is stable for retries.
module write_through_buffer #(
    parameter int unsigned FE_ADDR_W = 32,
    parameter int unsigned FE_DATA_W = 32,
    parameter int unsigned DEPTH_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    write_through_buffer_if.slave bus
);
    localparam int unsigned FE_NBYTES = FE_DATA_W / 8;
    localparam int unsigned FE_BYTE_W = $clog2(FE_NBYTES);
    localparam int unsigned ADDR_W    = FE_ADDR_W - FE_BYTE_W;
    localparam int unsigned DEPTH     = 2 ** DEPTH_W;
    localparam int unsigned CNT_W     = DEPTH_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [FE_DATA_W-1:0] data;
        logic [FE_NBYTES-1:0] strb;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    entry_t             entries [DEPTH];
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               full_c;
    logic               push_ok_c;
    logic               pop_c;
    logic               valid_c;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
    assign full_c    = (count == CNT_W'(DEPTH));
    assign push_ok_c = bus.wtb_push & ~full_c;

    // Next-state and channel handshake decode.
    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                valid_c = (count != '0);
                if (valid_c && bus.mem_ready) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // In BUSY, valid flags a further entry queued behind the in-flight head.
                valid_c = (count > CNT_W'(1));
                if (bus.mem_ready) begin
                    pop_c     = 1'b1;
                    state_nxt = valid_c ? BUSY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer, occupancy and overflow-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= bus.wtb_push & full_c;
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + DEPTH_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + DEPTH_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            entries[wr_ptr] <= '{addr: bus.wtb_addr, data: bus.wtb_wdata, strb: bus.wtb_wstrb};
        end
    end

    assign bus.wtb_full  = full_c;
    assign bus.wtb_empty = (count == '0);
    assign bus.wtb_level = count;
    assign bus.wtb_ovf   = ovf;
    assign bus.mem_valid = valid_c;
    assign bus.mem_addr  = entries[rd_ptr].addr;
    assign bus.mem_wdata = entries[rd_ptr].data;
    assign bus.mem_wstrb = entries[rd_ptr].strb;
endmodule

// File: tb/tb_write_through_buffer.sv
// Directed bench for write_through_buffer: queue-based reference model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_write_through_buffer;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    ent_t q[$];
    bit   inflight = 1'b0;
    bit   m_ovf = 1'b0;

    write_through_buffer_if #(.FE_ADDR_W(32), .FE_DATA_W(32), .DEPTH_W(2)) bus ();

    write_through_buffer #(.FE_ADDR_W(32), .FE_DATA_W(32), .DEPTH_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of posted writes plus a flag for "head has been handed to the channel".
    always @(posedge clk) begin : model
        int  sz;
        bit  take;
        ent_t e;
        if (reset) begin
            q.delete();
            inflight = 1'b0;
            m_ovf = 1'b0;
        end else begin
            sz = q.size();
            take = bus.wtb_push && (sz < DEPTH);
            m_ovf = bus.wtb_push && (sz == DEPTH);
            e.addr = bus.wtb_addr;
            e.data = bus.wtb_wdata;
            e.strb = bus.wtb_wstrb;
            if (inflight) begin
                if (bus.mem_ready) begin
                    void'(q.pop_front());
                    inflight = (sz > 1);
                end
            end else if (sz > 0 && bus.mem_ready) begin
                inflight = 1'b1;
            end
            if (take) q.push_back(e);
        end
    end

    always @(negedge clk) begin : compare
        int sz;
        if (chk_en) begin
            sz = q.size();
            check("level", 64'(bus.wtb_level), 64'(sz));
            check("empty", 64'(bus.wtb_empty), 64'(sz == 0));
            check("full", 64'(bus.wtb_full), 64'(sz == DEPTH));
            check("ovf", 64'(bus.wtb_ovf), 64'(m_ovf));
            check("mem_valid", 64'(bus.mem_valid), 64'(inflight ? (sz > 1) : (sz > 0)));
            if (sz > 0) begin
                check("mem_addr", 64'(bus.mem_addr), 64'(q[0].addr));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(q[0].data));
                check("mem_wstrb", 64'(bus.mem_wstrb), 64'(q[0].strb));
            end
        end
    end

    task automatic step(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic r);
        bus.wtb_push  = p;
        bus.wtb_addr  = a;
        bus.wtb_wdata = d;
        bus.wtb_wstrb = s;
        bus.mem_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        step(1'b0, '0, '0, '0, r);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        step(1'b0, '0, '0, '0, 1'b0);
        chk_en = 1'b1;
        idle(1'b0);
        check("rst_level", 64'(bus.wtb_level), 64'd0);
        check("rst_empty", 64'(bus.wtb_empty), 64'd1);
        check("rst_valid", 64'(bus.mem_valid), 64'd0);
        reset = 1'b0;

        // 1: single write 0x100 -> word address 0x40, fall-through then 3-cycle completion
        step(1'b1, 30'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        check("t1_valid", 64'(bus.mem_valid), 64'd1);
        check("t1_level", 64'(bus.wtb_level), 64'd1);
        idle(1'b1);
        check("t1_busy_valid", 64'(bus.mem_valid), 64'd0);
        check("t1_addr", 64'(bus.mem_addr), 64'h40);
        idle(1'b0);
        idle(1'b0);
        check("t1_hold_data", 64'(bus.mem_wdata), 64'hDEADBEEF);
        check("t1_not_empty", 64'(bus.wtb_empty), 64'd0);
        idle(1'b1);
        check("t1_empty", 64'(bus.wtb_empty), 64'd1);

        // 2: fill to DEPTH, then overflow
        for (int i = 0; i < 4; i++)
            step(1'b1, AW'(32'h10 + i), DW'(32'h1111_0000 + i), SW'(i + 1), 1'b0);
        check("t2_full", 64'(bus.wtb_full), 64'd1);
        check("t2_level", 64'(bus.wtb_level), 64'd4);
        step(1'b1, 30'h99, 32'hBAD0BAD0, 4'hF, 1'b0);
        check("t2_ovf", 64'(bus.wtb_ovf), 64'd1);
        check("t2_level_ovf", 64'(bus.wtb_level), 64'd4);
        idle(1'b0);
        check("t2_ovf_pulse", 64'(bus.wtb_ovf), 64'd0);
        check("t2_head", 64'(bus.mem_addr), 64'h10);

        // 3: full, push coincides with completion -> refused, pop still happens
        idle(1'b1);
        step(1'b1, 30'h77, 32'h7777_7777, 4'h3, 1'b1);
        check("t3_ovf", 64'(bus.wtb_ovf), 64'd1);
        check("t3_level", 64'(bus.wtb_level), 64'd3);
        check("t3_head", 64'(bus.mem_addr), 64'h11);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t3_drained", 64'(bus.wtb_empty), 64'd1);

        // 4: level 2, push on completion edge keeps level, order A,B,C preserved
        step(1'b1, 30'h0A, 32'hAAAA_0001, 4'h1, 1'b0);
        step(1'b1, 30'h0B, 32'hBBBB_0002, 4'h2, 1'b0);
        idle(1'b1);
        step(1'b1, 30'h0C, 32'hCCCC_0003, 4'h4, 1'b1);
        check("t4_level", 64'(bus.wtb_level), 64'd2);
        check("t4_head_b", 64'(bus.mem_addr), 64'h0B);
        idle(1'b1);
        check("t4_head_c", 64'(bus.mem_addr), 64'h0C);
        check("t4_strb_c", 64'(bus.mem_wstrb), 64'h4);
        idle(1'b1);
        check("t4_empty", 64'(bus.wtb_empty), 64'd1);

        // 5: completion delayed 10 cycles, head held stable
        step(1'b1, 30'h3FFF_FFFF, 32'h5A5A_A5A5, 4'hC, 1'b0);
        idle(1'b1);
        a0 = bus.mem_addr;
        d0 = bus.mem_wdata;
        check("t5_addr0", 64'(a0), 64'h3FFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            check("t5_addr_hold", 64'(bus.mem_addr), 64'h3FFF_FFFF);
            check("t5_data_hold", 64'(bus.mem_wdata), 64'(d0));
        end
        idle(1'b1);
        check("t5_empty", 64'(bus.wtb_empty), 64'd1);

        // 6: reset while BUSY with three entries
        for (int i = 0; i < 3; i++)
            step(1'b1, AW'(32'h20 + i), DW'(32'h2222_0000 + i), 4'hF, 1'b0);
        idle(1'b1);
        check("t6_level_pre", 64'(bus.wtb_level), 64'd3);
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        check("t6_level", 64'(bus.wtb_level), 64'd0);
        check("t6_empty", 64'(bus.wtb_empty), 64'd1);
        check("t6_valid", 64'(bus.mem_valid), 64'd0);
        step(1'b1, 30'h55, 32'h5555_5555, 4'h5, 1'b0);
        check("t6_restart_valid", 64'(bus.mem_valid), 64'd1);
        check("t6_restart_addr", 64'(bus.mem_addr), 64'h55);
        idle(1'b1);
        idle(1'b1);
        check("t6_final_empty", 64'(bus.wtb_empty), 64'd1);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
